// File: rtl/jpeg_fifo_byte_drain_if.sv
// Bundle of the FIFO read side and the outgoing byte stream of jpeg_fifo_byte_drain.
// slave is the drain's view; master is the view of whatever drives it (FIFO and host side).
interface jpeg_fifo_byte_drain_if #(
  parameter int unsigned CNT_W = 24
) ();
  logic             fifo_empty;
  logic [31:0]      read_data;
  logic             rdata_valid;
  logic             read_req;
  logic             eoi_in;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             done;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] stuff_cnt;

  modport slave (
    input  fifo_empty, read_data, rdata_valid, eoi_in, byte_ready,
    output read_req, byte_out, byte_valid, done, byte_cnt, stuff_cnt
  );

  modport master (
    output fifo_empty, read_data, rdata_valid, eoi_in, byte_ready,
    input  read_req, byte_out, byte_valid, done, byte_cnt, stuff_cnt
  );
endinterface

// File: rtl/jpeg_fifo_byte_drain.sv
// jpeg_fifo_byte_drain: pops 32-bit words from the encoder output FIFO, emits them
// MSB-first as a valid/ready byte stream with JPEG 0xFF->0xFF,0x00 stuffing, and
// pulses done once the image is fully drained after eoi_in.
// Optional: define JPEG_DRAIN_EOI_MARKER_EN to append an unstuffed FF,D9 EOI marker
// before done.
module jpeg_fifo_byte_drain #(
  parameter int unsigned CNT_W = 24
) (
  input logic                    clk,
  input logic                    rst,
  jpeg_fifo_byte_drain_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_STUFF  = 3'd3;
`ifdef JPEG_DRAIN_EOI_MARKER_EN
  localparam logic [2:0] S_EOI_FF = 3'd4;
  localparam logic [2:0] S_EOI_D9 = 3'd5;
`endif
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             done_q, done_d;
  logic             eoi_pending_q, eoi_pending_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
  logic             xfer;

  // A byte moves when the registered valid meets downstream ready
  assign xfer = byte_valid_q & bus.byte_ready;

  // One pop per word, only from IDLE; held low throughout reset
  assign bus.read_req = ~rst & (state_q == S_IDLE) & ~bus.fifo_empty;

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.done       = done_q;
  assign bus.byte_cnt   = byte_cnt_q;
  assign bus.stuff_cnt  = stuff_cnt_q;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    idx_d         = idx_q;
    byte_cnt_d    = byte_cnt_q;
    stuff_cnt_d   = stuff_cnt_q;
    eoi_pending_d = eoi_pending_q | bus.eoi_in;
    byte_valid_d  = 1'b0;
    byte_out_d    = byte_out_q;
    done_d        = 1'b0;

    if (xfer) byte_cnt_d = byte_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) begin
          state_d = S_WAIT;
        end else if (eoi_pending_q) begin
`ifdef JPEG_DRAIN_EOI_MARKER_EN
          state_d = S_EOI_FF;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_WAIT: begin
        if (bus.rdata_valid) begin
          word_d  = bus.read_data;
          idx_d   = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // byte_out_q holds the data byte currently offered
        if (xfer) begin
          if (byte_out_q == 8'hFF) state_d = S_STUFF;
          else if (idx_q == 2'd3)  state_d = S_IDLE;
          else                     idx_d   = idx_q + 2'd1;
        end
      end
      S_STUFF: begin
        if (xfer) begin
          stuff_cnt_d = stuff_cnt_q + CNT_W'(1);
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end
        end
      end
`ifdef JPEG_DRAIN_EOI_MARKER_EN
      S_EOI_FF: if (xfer) state_d = S_EOI_D9;
      S_EOI_D9: if (xfer) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Completion consumes the pending EOI; a coincident eoi_in is absorbed
    if ((state_d == S_DONE) && (state_q != S_DONE)) eoi_pending_d = 1'b0;

    // Outputs are registered from the state being entered so valid lines up with it
    case (state_d)
      S_SEND: begin
        byte_valid_d = 1'b1;
        case (idx_d)
          2'd0:    byte_out_d = word_d[31:24];
          2'd1:    byte_out_d = word_d[23:16];
          2'd2:    byte_out_d = word_d[15:8];
          default: byte_out_d = word_d[7:0];
        endcase
      end
      S_STUFF: begin
        byte_valid_d = 1'b1;
        byte_out_d   = 8'h00;
      end
`ifdef JPEG_DRAIN_EOI_MARKER_EN
      S_EOI_FF: begin
        byte_valid_d = 1'b1;
        byte_out_d   = 8'hFF;
      end
      S_EOI_D9: begin
        byte_valid_d = 1'b1;
        byte_out_d   = 8'hD9;
      end
`endif
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      idx_q         <= 2'd0;
      byte_out_q    <= 8'h00;
      byte_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      eoi_pending_q <= 1'b0;
      byte_cnt_q    <= '0;
      stuff_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      done_q        <= done_d;
      eoi_pending_q <= eoi_pending_d;
      byte_cnt_q    <= byte_cnt_d;
      stuff_cnt_q   <= stuff_cnt_d;
    end
  end

endmodule

// File: tb/tb_jpeg_fifo_byte_drain.sv
// Bench for jpeg_fifo_byte_drain: behavioural FIFO plus an expected-byte scoreboard.
// Honours JPEG_DRAIN_EOI_MARKER_EN the same way the design does.
module tb_jpeg_fifo_byte_drain;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [7:0] b;
    logic       stuff;
  } exp_t;

  logic clk;
  logic rst;

  jpeg_fifo_byte_drain_if #(.CNT_W(CNT_W)) bus ();

  jpeg_fifo_byte_drain #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  exp_t        exp_q[$];
  int          vecs = 0;
  int          fails = 0;
  int          m_byte_cnt = 0;
  int          m_stuff_cnt = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          rr_cyc = -1;
  int          bv_cyc = -1;
  logic        s_rr = 1'b0;
  logic        hold_valid = 1'b0;
  logic [7:0]  hold_byte = 8'h00;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: sample and score outputs, then update the FIFO model after the edge
  task automatic tick();
    logic s_xfer;
    logic [7:0] s_bo;
    exp_t e;
    #1;
    s_rr   = bus.read_req;
    s_bo   = bus.byte_out;
    s_xfer = bus.byte_valid & bus.byte_ready;
    if (s_rr && rr_cyc < 0) rr_cyc = cyc;
    if (bus.byte_valid && bv_cyc < 0) bv_cyc = cyc;
    vecs++;
    if (bus.byte_cnt !== CNT_W'(m_byte_cnt)) begin
      fails++;
      $display("FAIL byte_cnt cyc=%0d got %0d want %0d", cyc, bus.byte_cnt, CNT_W'(m_byte_cnt));
    end
    vecs++;
    if (bus.stuff_cnt !== CNT_W'(m_stuff_cnt)) begin
      fails++;
      $display("FAIL stuff_cnt cyc=%0d got %0d want %0d", cyc, bus.stuff_cnt, CNT_W'(m_stuff_cnt));
    end
    if (hold_valid) begin
      vecs++;
      if (bus.byte_valid !== 1'b1 || bus.byte_out !== hold_byte) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d got valid=%b byte=%h want valid=1 byte=%h",
                 cyc, bus.byte_valid, bus.byte_out, hold_byte);
      end
    end
    hold_valid = bus.byte_valid & ~bus.byte_ready;
    hold_byte  = bus.byte_out;
    if (bus.done === 1'b1) done_cnt++;
    if (s_xfer) begin
      vecs++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_byte cyc=%0d got %h want none", cyc, s_bo);
      end else begin
        e = exp_q.pop_front();
        if (s_bo !== e.b) begin
          fails++;
          $display("FAIL byte_out cyc=%0d got %h want %h", cyc, s_bo, e.b);
        end
      end
      m_byte_cnt++;
      if (e.stuff) m_stuff_cnt++;
      xfer_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.rdata_valid = 1'b0;
    if (s_rr) begin
      if (fifo_q.size() > 0) bus.read_data = fifo_q.pop_front();
      bus.rdata_valid = 1'b1;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic exp_word(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      exp_q.push_back('{b: b, stuff: 1'b0});
      if (b == 8'hFF) exp_q.push_back('{b: 8'h00, stuff: 1'b1});
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
    exp_word(w);
  endtask

  task automatic pulse_eoi();
`ifdef JPEG_DRAIN_EOI_MARKER_EN
    exp_q.push_back('{b: 8'hFF, stuff: 1'b0});
    exp_q.push_back('{b: 8'hD9, stuff: 1'b0});
`endif
    bus.eoi_in = 1'b1;
    tick();
    bus.eoi_in = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    vecs++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d bytes left want 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    vecs++;
    if (done_cnt == 0) begin
      fails++;
      $display("FAIL done_timeout got no done pulse within %0d cycles", bound);
    end
    vecs++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL done_early got %0d bytes outstanding want 0", exp_q.size());
    end
    repeat (5) tick();
    vecs++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL done_once got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_q.delete();
    m_byte_cnt = 0;
    m_stuff_cnt = 0;
    hold_valid = 1'b0;
    bus.eoi_in = 1'b0;
    bus.rdata_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (bus.read_req !== 1'b0 || bus.byte_valid !== 1'b0 || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL reset_ctl got rr=%b bv=%b done=%b want 0/0/0", bus.read_req, bus.byte_valid, bus.done);
      end
      vecs++;
      if (bus.byte_out !== 8'h00 || bus.byte_cnt !== '0 || bus.stuff_cnt !== '0) begin
        fails++;
        $display("FAIL reset_data got byte=%h bcnt=%0d scnt=%0d want 00/0/0", bus.byte_out, bus.byte_cnt, bus.stuff_cnt);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base = xfer_cnt;
    int n = 0;
    bus.byte_ready = 1'b1;
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    while (xfer_cnt - base < 2 && n < 20) begin
      tick();
      n++;
    end
    test_reset();
    exp_word(32'h01020304);
    drain(40);
    vecs++;
    if (bus.byte_cnt !== CNT_W'(4)) begin
      fails++;
      $display("FAIL reset_mid_cnt got %0d want 4", bus.byte_cnt);
    end
  endtask

  task automatic test_single();
    rr_cyc = -1;
    bv_cyc = -1;
    bus.byte_ready = 1'b1;
    push_word(32'h12345678);
    drain(40);
    vecs++;
    if (bv_cyc - rr_cyc != 2) begin
      fails++;
      $display("FAIL latency got %0d want 2", bv_cyc - rr_cyc);
    end
    vecs++;
    if (bus.byte_cnt !== CNT_W'(8) || bus.stuff_cnt !== CNT_W'(0)) begin
      fails++;
      $display("FAIL single_cnt got %0d/%0d want 8/0", bus.byte_cnt, bus.stuff_cnt);
    end
  endtask

  task automatic test_stuffing();
    int base = xfer_cnt;
    int n_rr = 0;
    int n = 0;
    bus.byte_ready = 1'b1;
    push_word(32'h12FF34FF);
    push_word(32'hA1B2C3D4);
    while (exp_q.size() > 0 && n < 60) begin
      tick();
      n++;
      if (s_rr) begin
        n_rr++;
        if (n_rr == 2) begin
          vecs++;
          if (xfer_cnt - base != 6) begin
            fails++;
            $display("FAIL second_read got %0d bytes before it want 6", xfer_cnt - base);
          end
        end
      end
    end
    drain(10);
    vecs++;
    if (bus.byte_cnt !== CNT_W'(18) || bus.stuff_cnt !== CNT_W'(2)) begin
      fails++;
      $display("FAIL stuff_cnt_total got %0d/%0d want %0d/2", bus.byte_cnt, bus.stuff_cnt, CNT_W'(18));
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    push_word(32'hFFFFFFFF);
    bus.byte_ready = 1'b1;
    while (exp_q.size() > 0 && n < 80) begin
      tick();
      bus.byte_ready = ~bus.byte_ready;
      n++;
    end
    bus.byte_ready = 1'b1;
    drain(10);
    vecs++;
    if (bus.byte_cnt !== CNT_W'(26) || bus.stuff_cnt !== CNT_W'(6)) begin
      fails++;
      $display("FAIL bp_cnt got %0d/%0d want %0d/6", bus.byte_cnt, bus.stuff_cnt, CNT_W'(26));
    end
  endtask

  task automatic test_eoi_two_words();
    int n = 0;
    done_cnt = 0;
    bus.byte_ready = 1'b1;
    push_word(32'h0BADF00D);
    push_word(32'hCAFEBABE);
    while (bv_cyc >= 0 && n < 1) n++;
    n = 0;
    while (bus.byte_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    pulse_eoi();
    wait_done(100);
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] exp_b;
    test_reset();
    done_cnt = 0;
    bus.byte_ready = 1'b1;
    push_word(32'hFFFFFFFF);
    push_word(32'hFFFFFFFF);
    push_word(32'hFFFFFFFF);
    push_word(32'hFFFFFF11);
    drain(150);
    vecs++;
    if (bus.byte_cnt !== CNT_W'(15) || bus.stuff_cnt !== CNT_W'(15)) begin
      fails++;
      $display("FAIL preload got %0d/%0d want 15/15", bus.byte_cnt, bus.stuff_cnt);
    end
    pulse_eoi();
    wait_done(40);
`ifdef JPEG_DRAIN_EOI_MARKER_EN
    exp_b = CNT_W'(1);
`else
    exp_b = CNT_W'(15);
`endif
    vecs++;
    if (bus.byte_cnt !== exp_b || bus.stuff_cnt !== CNT_W'(15)) begin
      fails++;
      $display("FAIL eoi_wrap got %0d/%0d want %0d/15", bus.byte_cnt, bus.stuff_cnt, exp_b);
    end
    push_word(32'hFF000000);
    drain(40);
    vecs++;
    if (bus.stuff_cnt !== CNT_W'(0) || bus.byte_cnt !== exp_b + CNT_W'(5)) begin
      fails++;
      $display("FAIL stuff_wrap got %0d/%0d want %0d/0", bus.byte_cnt, bus.stuff_cnt, exp_b + CNT_W'(5));
    end
    vecs++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL done_after_restart got %0d pulses want 1", done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.fifo_empty  = 1'b1;
    bus.read_data   = 32'h0;
    bus.rdata_valid = 1'b0;
    bus.eoi_in      = 1'b0;
    bus.byte_ready  = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_reset_mid();
    test_single();
    test_stuffing();
    test_backpressure();
    test_eoi_two_words();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
